// File: rtl/panda_pkg.sv
// rtl/panda_pkg.sv - shared LSU types and access-shaping helpers
// Contents:
//   lsu_size_e      access size (LsuByte / LsuHalf / LsuWord)
//   lsu_misaligned  1 when an access of the given size is misaligned at the byte offset
//   lsu_be          byte enables for a size at a byte offset within the word
//   lsu_wdata       store data replicated across every lane a size can occupy
package panda_pkg;

    typedef enum logic [1:0] {
        LsuByte = 2'd0,
        LsuHalf = 2'd1,
        LsuWord = 2'd2
    } lsu_size_e;

    // The unused encoding is treated like a word everywhere so that the
    // misalignment check, byte enables and store lanes stay consistent.
    function automatic logic lsu_misaligned(input lsu_size_e size, input logic [1:0] off);
        case (size)
            LsuByte: return 1'b0;
            LsuHalf: return off[0];
            default: return |off;
        endcase
    endfunction

    function automatic logic [3:0] lsu_be(input lsu_size_e size, input logic [1:0] off);
        case (size)
            LsuByte: return 4'b0001 << off;
            LsuHalf: return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicating the data means the memory picks the right lane from the
    // byte enables alone; no shifter is needed on the store path.
    function automatic logic [31:0] lsu_wdata(input lsu_size_e size, input logic [31:0] wdata);
        case (size)
            LsuByte: return {4{wdata[7:0]}};
            LsuHalf: return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage

// File: rtl/panda_lsu_extract.sv
// rtl/panda_lsu_extract.sv - load lane selection and sign/zero extension
// Ports:
//   rdata_i     raw 32-bit word returned by data memory
//   offset_i    byte offset of the access within the word
//   size_i      access size
//   unsigned_i  1 = zero-extend, 0 = sign-extend
//   data_o      LSB-aligned, extended load result
module panda_lsu_extract
    import panda_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  lsu_size_e   size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Picking the lane with part-selects is the same as shifting right by
    // 8*offset and keeping the low bits. Halves are aligned, so offset[1]
    // alone selects the lane.
    assign byte_sel = rdata_i[{offset_i, 3'b000} +: 8];
    assign half_sel = rdata_i[{offset_i[1], 4'b0000} +: 16];

    always_comb begin
        data_o = rdata_i;
        case (size_i)
            LsuByte: data_o = {{24{byte_sel[7] & ~unsigned_i}}, byte_sel};
            LsuHalf: data_o = {{16{half_sel[15] & ~unsigned_i}}, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/panda_lsu.sv
// rtl/panda_lsu.sv - load/store unit with a request/grant/rvalid data port
// Ports:
//   clk_i, rst_i                    clock, asynchronous active-high reset
//   req_i, we_i, size_i, unsigned_i memory op from execute, sampled while idle
//   addr_i, wdata_i                 byte address and LSB-aligned store data
//   busy_o                          transaction outstanding
//   valid_o, rdata_o                one-cycle completion pulse with load result (0 for stores)
//   err_o                           one-cycle misaligned-access pulse
//   data_req_o .. data_rdata_i      data memory request/grant/response port
module panda_lsu
    import panda_pkg::*;
#(
    parameter int Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_i,
    input  logic             we_i,
    input  lsu_size_e        size_i,
    input  logic             unsigned_i,
    input  logic [Width-1:0] addr_i,
    input  logic [Width-1:0] wdata_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic [Width-1:0] rdata_o,
    output logic             err_o,
    output logic             data_req_o,
    input  logic             data_gnt_i,
    output logic [Width-1:0] data_addr_o,
    output logic             data_we_o,
    output logic [3:0]       data_be_o,
    output logic [Width-1:0] data_wdata_o,
    input  logic             data_rvalid_i,
    input  logic [Width-1:0] data_rdata_i
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_GNT    = 2'd1,
        WAIT_RVALID = 2'd2
    } state_e;

    state_e           state;
    logic [Width-1:0] addr_q;
    logic [Width-1:0] wdata_q;
    logic [3:0]       be_q;
    logic             we_q;
    lsu_size_e        size_q;
    logic             unsigned_q;

    logic             in_idle;
    logic             misaligned;
    logic             issue;
    logic [Width-1:0] load_data;

    assign in_idle    = (state == IDLE);
    assign misaligned = req_i && lsu_misaligned(size_i, addr_i[1:0]);
    assign issue      = req_i && !misaligned;

    // While idle the request is presented straight from the inputs so a
    // same-cycle grant costs no extra cycle; afterwards the captured copy
    // keeps the attributes stable no matter what execute drives.
    assign busy_o       = !in_idle;
    assign data_req_o   = (in_idle && issue) || (state == WAIT_GNT);
    assign data_addr_o  = in_idle ? {addr_i[Width-1:2], 2'b00} : {addr_q[Width-1:2], 2'b00};
    assign data_we_o    = in_idle ? we_i : we_q;
    assign data_be_o    = in_idle ? lsu_be(size_i, addr_i[1:0]) : be_q;
    assign data_wdata_o = in_idle ? lsu_wdata(size_i, wdata_i) : wdata_q;

    panda_lsu_extract u_extract (
        .rdata_i    (data_rdata_i),
        .offset_i   (addr_q[1:0]),
        .size_i     (size_q),
        .unsigned_i (unsigned_q),
        .data_o     (load_data)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            valid_o    <= 1'b0;
            err_o      <= 1'b0;
            rdata_o    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            we_q       <= 1'b0;
            size_q     <= LsuByte;
            unsigned_q <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            err_o   <= 1'b0;
            case (state)
                IDLE: begin
                    if (misaligned) begin
                        err_o <= 1'b1;
                    end else if (issue) begin
                        // Captured even on a same-cycle grant: the offset,
                        // size and signedness are needed when data returns.
                        addr_q     <= addr_i;
                        wdata_q    <= lsu_wdata(size_i, wdata_i);
                        be_q       <= lsu_be(size_i, addr_i[1:0]);
                        we_q       <= we_i;
                        size_q     <= size_i;
                        unsigned_q <= unsigned_i;
                        state      <= data_gnt_i ? WAIT_RVALID : WAIT_GNT;
                    end
                end
                WAIT_GNT: begin
                    if (data_gnt_i) begin
                        state <= WAIT_RVALID;
                    end
                end
                WAIT_RVALID: begin
                    if (data_rvalid_i) begin
                        state   <= IDLE;
                        valid_o <= 1'b1;
                        rdata_o <= we_q ? '0 : load_data;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_panda_lsu.sv
// tb/tb_panda_lsu.sv - self-checking bench for panda_lsu with a memory-side responder
module tb_panda_lsu;
    import panda_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic        we_i;
    lsu_size_e   size_i;
    logic        unsigned_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        busy_o;
    logic        valid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        data_req_o;
    logic        data_gnt_i;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;

    int compared   = 0;
    int mismatched = 0;

    panda_lsu #(.Width(32)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .req_i         (req_i),
        .we_i          (we_i),
        .size_i        (size_i),
        .unsigned_i    (unsigned_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .busy_o        (busy_o),
        .valid_o       (valid_o),
        .rdata_o       (rdata_o),
        .err_o         (err_o),
        .data_req_o    (data_req_o),
        .data_gnt_i    (data_gnt_i),
        .data_addr_o   (data_addr_o),
        .data_we_o     (data_we_o),
        .data_be_o     (data_be_o),
        .data_wdata_o  (data_wdata_o),
        .data_rvalid_i (data_rvalid_i),
        .data_rdata_i  (data_rdata_i)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed no end of run, expected finish before 400us");
        $fatal(1, "watchdog expired");
    end

    // Reference model: plain arithmetic on byte offsets.
    function automatic logic [31:0] m_be(input lsu_size_e s, input logic [31:0] a);
        int off = int'(a % 4);
        case (s)
            LsuByte: return 32'(1 << off);
            LsuHalf: return 32'(3 << off);
            default: return 32'd15;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input lsu_size_e s, input logic [31:0] w);
        case (s)
            LsuByte: return (w % 256) * 32'h0101_0101;
            LsuHalf: return (w % 65536) * 32'h0001_0001;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic we, input lsu_size_e s, input logic uns,
                                           input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        if (we) return 32'd0;
        v = rd >> (8 * (a % 4));
        case (s)
            LsuByte: begin
                v = v % 256;
                if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
            end
            LsuHalf: begin
                v = v % 65536;
                if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
            end
            default: v = rd;
        endcase
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Execute drives junk while the LSU is busy; it must all be ignored.
    task automatic drive_junk();
        req_i      = 1'b1;
        we_i       = 1'($urandom);
        size_i     = lsu_size_e'($urandom_range(0, 2));
        unsigned_i = 1'($urandom);
        addr_i     = $urandom;
        wdata_i    = $urandom;
    endtask

    // Starts on a negedge with the LSU idle; returns on the negedge of the
    // valid_o cycle so a following call issues back-to-back.
    task automatic do_op(input logic we, input lsu_size_e s, input logic uns,
                         input logic [31:0] a, input logic [31:0] w,
                         input int gdly, input int rdly, input logic [31:0] rd);
        logic [31:0] exp_addr = {a[31:2], 2'b00};
        req_i = 1'b1; we_i = we; size_i = s; unsigned_i = uns; addr_i = a; wdata_i = w;
        data_rvalid_i = 1'b0;
        for (int c = 0; c <= gdly; c++) begin
            if (c > 0) drive_junk();
            data_gnt_i = (c == gdly);
            #1;
            check("req", data_req_o, 1);
            check("addr", data_addr_o, exp_addr);
            check("we", data_we_o, we);
            check("be", data_be_o, m_be(s, a));
            check("wdata", data_wdata_o, m_wdata(s, w));
            check("busy_req", busy_o, (c > 0));
            @(negedge clk);
        end
        for (int c = 0; c <= rdly; c++) begin
            drive_junk();
            data_gnt_i    = 1'($urandom);
            data_rvalid_i = (c == rdly);
            data_rdata_i  = (c == rdly) ? rd : $urandom;
            #1;
            check("req_wait_rvalid", data_req_o, 0);
            check("busy_wait_rvalid", busy_o, 1);
            check("valid_early", valid_o, 0);
            check("err_busy", err_o, 0);
            @(negedge clk);
        end
        req_i = 1'b0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
        check("valid", valid_o, 1);
        check("rdata", rdata_o, m_load(we, s, uns, a, rd));
        check("busy_done", busy_o, 0);
    endtask

    // Starts and ends on a negedge with the LSU idle.
    task automatic do_mis(input lsu_size_e s, input logic [31:0] a);
        req_i = 1'b1; we_i = 1'($urandom); size_i = s; addr_i = a; wdata_i = $urandom;
        data_gnt_i = 1'b1;
        #1;
        check("mis_req", data_req_o, 0);
        check("mis_busy", busy_o, 0);
        @(negedge clk);
        req_i = 1'b0; data_gnt_i = 1'b0;
        check("mis_err", err_o, 1);
        check("mis_busy2", busy_o, 0);
        check("mis_valid", valid_o, 0);
        @(negedge clk);
        check("mis_err_once", err_o, 0);
        check("mis_busy3", busy_o, 0);
    endtask

    task automatic idle_cycle();
        req_i = 1'b0;
        @(negedge clk);
        check("valid_once", valid_o, 0);
    endtask

    initial begin
        rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; size_i = LsuWord; unsigned_i = 1'b0;
        addr_i = 32'd0; wdata_i = 32'd0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
        data_rdata_i = 32'd0;
        @(negedge clk);
        #1;
        check("rst_busy", busy_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_err", err_o, 0);
        check("rst_rdata", rdata_o, 0);
        check("rst_req", data_req_o, 0);
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);

        // Load word, same-cycle grant, rvalid next cycle: minimum latency.
        do_op(1'b0, LsuWord, 1'b0, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF);
        check("lw_value", rdata_o, 32'hDEADBEEF);
        idle_cycle();
        // Load byte signed and unsigned from the top lane.
        do_op(1'b0, LsuByte, 1'b0, 32'h103, 32'h0, 0, 0, 32'h80FF0000);
        check("lb_value", rdata_o, 32'hFFFFFF80);
        idle_cycle();
        do_op(1'b0, LsuByte, 1'b1, 32'h103, 32'h0, 0, 0, 32'h80FF0000);
        check("lbu_value", rdata_o, 32'h00000080);
        idle_cycle();
        // Store half with a 3-cycle grant delay.
        do_op(1'b1, LsuHalf, 1'b0, 32'h102, 32'h1234ABCD, 3, 1, 32'hFFFFFFFF);
        check("sh_rdata_zero", rdata_o, 32'h0);
        idle_cycle();
        // Misaligned word.
        do_mis(LsuWord, 32'h101);

        // Reset while waiting for rvalid; a late rvalid must be ignored.
        req_i = 1'b1; we_i = 1'b0; size_i = LsuWord; addr_i = 32'h200; data_gnt_i = 1'b1;
        @(negedge clk);
        req_i = 1'b0; data_gnt_i = 1'b0;
        check("pre_rst_busy", busy_o, 1);
        rst_i = 1'b1;
        #1;
        check("midrst_busy", busy_o, 0);
        check("midrst_req", data_req_o, 0);
        @(negedge clk);
        rst_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = 32'h12345678;
        #1;
        check("late_rvalid_busy", busy_o, 0);
        check("late_rvalid_req", data_req_o, 0);
        @(negedge clk);
        data_rvalid_i = 1'b0;
        check("late_rvalid_valid", valid_o, 0);
        @(negedge clk);
        check("late_rvalid_valid2", valid_o, 0);

        // Back-to-back loads: the second issues in the first one's valid cycle.
        do_op(1'b0, LsuHalf, 1'b0, 32'h302, 32'h0, 0, 0, 32'h8001_7FFF);
        check("b2b_first", rdata_o, 32'hFFFF8001);
        do_op(1'b0, LsuWord, 1'b0, 32'h304, 32'h0, 1, 2, 32'hCAFEF00D);
        check("b2b_second", rdata_o, 32'hCAFEF00D);
        idle_cycle();

        // Randomized mix, including misaligned accesses and back-to-back issue.
        for (int n = 0; n < 80; n++) begin
            logic [31:0] a = $urandom;
            lsu_size_e   s = lsu_size_e'($urandom_range(0, 2));
            if ($urandom_range(0, 4) == 0 && s != LsuByte) begin
                if (s == LsuHalf) a[0] = 1'b1;
                else a[1:0] = 2'($urandom_range(1, 3));
                do_mis(s, a);
            end else begin
                if (s == LsuHalf) a[0] = 1'b0;
                if (s == LsuWord) a[1:0] = 2'b00;
                do_op(1'($urandom), s, 1'($urandom), a, $urandom,
                      $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
                if ($urandom_range(0, 1) == 0) idle_cycle();
            end
        end
        idle_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
